pe_array_seq: RTL and testbench
===============================

PE_ARRAY_SEQ -- requirements
Module: pe_array_seq

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 54, modulus width, matching the PE array.
- ADDR_WIDTH, 10, operand/result buffer address width.
- PE_LATENCY, 4, PE array input-to-output latency in cycles.
- LEN_WIDTH, 11, job length field width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-high reset.
- cmd_valid, in, 1, job request.
- cmd_ready, out, 1, job accepted when cmd_valid and cmd_ready are both high.
- cmd_op, in, 2, PE operation code.
- cmd_len, in, LEN_WIDTH, number of vector rows N.
- cmd_src_base, in, ADDR_WIDTH, operand buffer start address.
- cmd_dst_base, in, ADDR_WIDTH, result buffer start address.
- cmd_modulus, in, DATA_WIDTH, job modulus.
- cmd_modulus_inv, in, DATA_WIDTH+1, job Barrett constant.
- ctrl_pe, out, 2, PE array operation.
- modulus, out, DATA_WIDTH, held modulus.
- modulus_inv, out, DATA_WIDTH+1, held constant.
- rd_en, out, 1, operand buffer read strobe; all three operand buffers share it.
- rd_addr, out, ADDR_WIDTH, operand buffer read address.
- wr_en, out, 1, result buffer write strobe.
- wr_addr, out, ADDR_WIDTH, result buffer write address.
- busy, out, 1, job in progress.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, one-cycle pulse on a rejected command.

Function
REQ-003 The FSM SHALL have four states: IDLE, ISSUE, DRAIN, DONE.
REQ-004 cmd_ready SHALL be 1 only in IDLE.
REQ-005 On accept, the block SHALL register cmd_op, cmd_len, both bases, cmd_modulus and cmd_modulus_inv.
REQ-006 The registered op, modulus and modulus_inv SHALL drive ctrl_pe, modulus and modulus_inv, unchanged until the next accept.
REQ-007 On accept with cmd_op==2'b11 (reserved), the block SHALL pulse err for 1 cycle, stay in IDLE, and leave ctrl_pe, modulus and modulus_inv unchanged.
REQ-008 On accept with cmd_len==0, the block SHALL go IDLE->DONE: no rd_en, no wr_en, and done pulses the next cycle.
REQ-009 Otherwise the block SHALL go IDLE->ISSUE on the cycle after accept.
REQ-010 In ISSUE, rd_en SHALL be 1 every cycle for exactly N consecutive cycles, with rd_addr = src_base + k for k = 0..N-1.
REQ-011 Read addresses SHALL wrap modulo 2^ADDR_WIDTH.
REQ-012 After the last issue, the FSM SHALL go ISSUE->DRAIN.
REQ-013 Pipeline latency SHALL be L = 1 + PE_LATENCY: one cycle of buffer read plus the PE array latency.
REQ-014 The valid/index shift pipeline SHALL be L deep.
REQ-015 wr_en for row k SHALL assert exactly L cycles after rd_en for row k.
REQ-016 wr_addr SHALL equal dst_base + k, wrapping modulo 2^ADDR_WIDTH.
REQ-017 There SHALL be no gaps in the write stream, and writes SHALL be in order.
REQ-018 A write counter SHALL count wr_en; when it reaches N, the FSM SHALL go DRAIN->DONE.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE the next cycle.
REQ-020 cmd_ready SHALL be 0 in DONE, so a back-to-back job is accepted no earlier than the cycle after done.
REQ-021 busy SHALL be 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
REQ-022 cmd_valid while not in IDLE SHALL be ignored, with no state change and no err.
REQ-023 For N >= 1, the job duration from the accept edge to the done pulse SHALL be N + L + 1 cycles.
REQ-024 Row and counter widths SHALL be LEN_WIDTH, and N = 2^LEN_WIDTH - 1 SHALL be supported without overflow.

Reset
REQ-025 While rst is high, all of the following SHALL be 0 asynchronously: FSM state (IDLE), counters, the valid pipeline, ctrl_pe, modulus, modulus_inv, rd_en, rd_addr, wr_en, wr_addr, busy, done and err.
REQ-026 cmd_ready SHALL be 0 while rst is high and 1 from the first clock edge after rst falls.
REQ-027 Reset asserted mid-job SHALL abort immediately: in-flight rows are discarded, no further wr_en, no done.

Verification (PE_LATENCY=4, L=5, ADDR_WIDTH=10)
REQ-028 Basic job: op=01, N=3, src=0x010, dst=0x200 -> rd_addr 0x010..0x012 on 3 consecutive cycles; wr_addr 0x200..0x202 each 5 cycles after its read; done 9 cycles after accept; ctrl_pe=01 throughout.
REQ-029 Wrap: N=4, src=0x3FE, dst=0x3FF -> rd_addr 0x3FE,0x3FF,0x000,0x001; wr_addr 0x3FF,0x000,0x001,0x002.
REQ-030 Edge commands: N=0 -> no rd_en/wr_en, done one cycle after accept; op=11 -> err pulse, cmd_ready stays 1, outputs unchanged.
REQ-031 Busy rejection: cmd_valid held high through a job of N=2 -> exactly one accept during the job; second accept the cycle after done; modulus switches only at the second accept.
REQ-032 Abort: rst pulsed 2 cycles after the first wr_en of an N=8 job -> all outputs 0 during reset; no wr_en or done afterwards; a fresh N=1 job then completes normally.

Source files
------------

// File: rtl/pe_array_seq.sv
// pe_array_seq: job sequencer for the modular PE array.
// Accepts one vector job at a time, streams N operand reads, tracks rows
// through the buffer-read + PE pipeline, and counts result writes to completion.
module pe_array_seq #(
  parameter int unsigned DATA_WIDTH = 54,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned PE_LATENCY = 4,
  parameter int unsigned LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [ADDR_WIDTH-1:0] cmd_src_base,
  input  logic [ADDR_WIDTH-1:0] cmd_dst_base,
  input  logic [DATA_WIDTH-1:0] cmd_modulus,
  input  logic [DATA_WIDTH:0]   cmd_modulus_inv,
  output logic [1:0]            ctrl_pe,
  output logic [DATA_WIDTH-1:0] modulus,
  output logic [DATA_WIDTH:0]   modulus_inv,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // One cycle of buffer read followed by the PE array latency.
  localparam int unsigned PIPE_L = 1 + PE_LATENCY;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_RESERVED = 2'b11;

  logic [1:0]            state_q,   state_d;
  logic [1:0]            op_q,      op_d;
  logic [LEN_WIDTH-1:0]  len_q,     len_d;
  logic [ADDR_WIDTH-1:0] src_q,     src_d;
  logic [ADDR_WIDTH-1:0] dst_q,     dst_d;
  logic [DATA_WIDTH-1:0] mod_q,     mod_d;
  logic [DATA_WIDTH:0]   inv_q,     inv_d;
  logic [LEN_WIDTH-1:0]  iss_cnt_q, iss_cnt_d;
  logic [LEN_WIDTH-1:0]  wr_cnt_q,  wr_cnt_d;
  logic [PIPE_L-1:0]     vld_q,     vld_d;
  logic [ADDR_WIDTH-1:0] idx_q [PIPE_L];
  logic [ADDR_WIDTH-1:0] idx_d [PIPE_L];
  logic                  err_q,     err_d;
  logic                  rdy_q;
  logic                  accept;

  // Handshake and datapath-facing outputs decoded from registered state.
  always_comb begin
    cmd_ready   = rdy_q && (state_q == S_IDLE);
    accept      = cmd_valid && cmd_ready;
    rd_en       = (state_q == S_ISSUE);
    rd_addr     = rd_en ? (src_q + ADDR_WIDTH'(iss_cnt_q)) : '0;
    wr_en       = vld_q[PIPE_L-1];
    wr_addr     = wr_en ? (dst_q + idx_q[PIPE_L-1]) : '0;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    err         = err_q;
    ctrl_pe     = op_q;
    modulus     = mod_q;
    modulus_inv = inv_q;
  end

  // Job FSM, command capture and issue/write counters.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    len_d     = len_q;
    src_d     = src_q;
    dst_d     = dst_q;
    mod_d     = mod_q;
    inv_d     = inv_q;
    iss_cnt_d = iss_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_RESERVED) begin
            err_d = 1'b1;
          end else begin
            op_d      = cmd_op;
            len_d     = cmd_len;
            src_d     = cmd_src_base;
            dst_d     = cmd_dst_base;
            mod_d     = cmd_modulus;
            inv_d     = cmd_modulus_inv;
            iss_cnt_d = '0;
            wr_cnt_d  = '0;
            state_d   = (cmd_len == '0) ? S_DONE : S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (iss_cnt_q == (len_q - LEN_WIDTH'(1))) begin
          state_d = S_DRAIN;
        end else begin
          iss_cnt_d = iss_cnt_q + LEN_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        if (wr_cnt_q == len_q) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Writes only occur outside IDLE, so this never collides with the clear on accept.
    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + LEN_WIDTH'(1);
    end
  end

  // Row valid/index shift pipeline; carries the wrapped row offset to the write side.
  always_comb begin
    vld_d[0] = rd_en;
    idx_d[0] = ADDR_WIDTH'(iss_cnt_q);
    for (int unsigned i = 1; i < PIPE_L; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  // State registers with asynchronous active-high clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      len_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      mod_q     <= '0;
      inv_q     <= '0;
      iss_cnt_q <= '0;
      wr_cnt_q  <= '0;
      vld_q     <= '0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
      for (int unsigned i = 0; i < PIPE_L; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      len_q     <= len_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      mod_q     <= mod_d;
      inv_q     <= inv_d;
      iss_cnt_q <= iss_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      rdy_q     <= 1'b1;
      for (int unsigned i = 0; i < PIPE_L; i++) begin
        idx_q[i] <= idx_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pe_array_seq.sv
// Scoreboard bench for pe_array_seq: each accepted job pushes its expected
// read, write, done and err events (cycle + address); a negedge monitor pops them.
module tb_pe_array_seq;

  localparam int DW = 54;
  localparam int AW = 10;
  localparam int PL = 4;
  localparam int LW = 11;
  localparam int L  = PL + 1;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] cmd_src_base;
  logic [AW-1:0] cmd_dst_base;
  logic [DW-1:0] cmd_modulus;
  logic [DW:0]   cmd_modulus_inv;
  logic [1:0]    ctrl_pe;
  logic [DW-1:0] modulus;
  logic [DW:0]   modulus_inv;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          busy;
  logic          done;
  logic          err;

  pe_array_seq #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .PE_LATENCY(PL),
    .LEN_WIDTH (LW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_len        (cmd_len),
    .cmd_src_base   (cmd_src_base),
    .cmd_dst_base   (cmd_dst_base),
    .cmd_modulus    (cmd_modulus),
    .cmd_modulus_inv(cmd_modulus_inv),
    .ctrl_pe        (ctrl_pe),
    .modulus        (modulus),
    .modulus_inv    (modulus_inv),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // cmd_ready may only rise on the first clock edge after reset release.
  logic rdy_allowed;
  always @(posedge clk or posedge rst) begin
    if (rst) rdy_allowed <= 1'b0;
    else     rdy_allowed <= 1'b1;
  end

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
  } ev_t;

  ev_t rdq[$];
  ev_t wrq[$];
  int  doneq[$];
  int  errq[$];
  int  win_lo = 1;
  int  win_hi = 0;

  int n_total = 0;
  int n_bad   = 0;

  logic [1:0]    h_op  = '0;
  logic [DW-1:0] h_mod = '0;
  logic [DW:0]   h_inv = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_strobes"}, {58'd0, rd_en, wr_en, busy, done, err, cmd_ready}, 64'd0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_ctrl_pe"}, ctrl_pe, 0);
    chk({tag, "_mod"},     modulus, 0);
    chk({tag, "_inv"},     modulus_inv, 0);
  endtask

  task automatic push_job(input int a, input logic [1:0] op, input int n,
                          input logic [AW-1:0] src, input logic [AW-1:0] dst);
    ev_t e;
    int  d;
    if (op == 2'b11) begin
      errq.push_back(a);
      return;
    end
    for (int k = 0; k < n; k++) begin
      e.cyc  = a + k;
      e.addr = src + AW'(k);
      rdq.push_back(e);
      e.cyc  = a + k + L;
      e.addr = dst + AW'(k);
      wrq.push_back(e);
    end
    d = (n == 0) ? a : a + n + L + 1;
    doneq.push_back(d);
    win_lo = a;
    win_hi = d;
  endtask

  // Monitor: busy/ready against the expected job window, events against the scoreboard.
  ev_t me;
  logic exp_busy;
  always @(negedge clk) begin
    if (!rst) begin
      exp_busy = (cyc >= win_lo) && (cyc <= win_hi);
      chk("busy", busy, exp_busy);
      chk("cmd_ready", cmd_ready, rdy_allowed && !exp_busy);
      if (rd_en) begin
        if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          me = rdq.pop_front();
          chk("rd_cyc", cyc, me.cyc);
          chk("rd_addr", rd_addr, me.addr);
        end
      end
      if (wr_en) begin
        if (wrq.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          me = wrq.pop_front();
          chk("wr_cyc", cyc, me.cyc);
          chk("wr_addr", wr_addr, me.addr);
        end
      end
      if (done) begin
        if (doneq.size() == 0) chk("done_unexpected", 1, 0);
        else chk("done_cyc", cyc, doneq.pop_front());
      end
      if (err) begin
        if (errq.size() == 0) chk("err_unexpected", 1, 0);
        else chk("err_cyc", cyc, errq.pop_front());
      end
      while (rdq.size() != 0 && rdq[0].cyc < cyc) begin
        chk("rd_missing", rdq[0].cyc, cyc);
        void'(rdq.pop_front());
      end
      while (wrq.size() != 0 && wrq[0].cyc < cyc) begin
        chk("wr_missing", wrq[0].cyc, cyc);
        void'(wrq.pop_front());
      end
      while (doneq.size() != 0 && doneq[0] < cyc) begin
        chk("done_missing", doneq[0], cyc);
        void'(doneq.pop_front());
      end
      while (errq.size() != 0 && errq[0] < cyc) begin
        chk("err_missing", errq[0], cyc);
        void'(errq.pop_front());
      end
    end
  end

  task automatic drive_cmd(input logic [1:0] op, input int n, input logic [AW-1:0] src,
                           input logic [AW-1:0] dst, input logic [DW-1:0] m,
                           input logic [DW:0] mi);
    cmd_op          = op;
    cmd_len         = LW'(n);
    cmd_src_base    = src;
    cmd_dst_base    = dst;
    cmd_modulus     = m;
    cmd_modulus_inv = mi;
    cmd_valid       = 1'b1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic submit(input logic [1:0] op, input int n, input logic [AW-1:0] src,
                        input logic [AW-1:0] dst, input logic [DW-1:0] m,
                        input logic [DW:0] mi, output int a);
    bit ok;
    @(posedge clk); #2;
    drive_cmd(op, n, src, dst, m, mi);
    wait_ready(ok);
    if (!ok) begin
      cmd_valid = 1'b0;
      a = -1;
      return;
    end
    a = cyc + 1;
    push_job(a, op, n, src, dst);
    if (op != 2'b11) begin
      h_op  = op;
      h_mod = m;
      h_inv = mi;
    end
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("ctrl_pe_after_accept", ctrl_pe, h_op);
    chk("mod_after_accept", modulus, h_mod);
    chk("inv_after_accept", modulus_inv, h_inv);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (rdq.size() == 0 && wrq.size() == 0 && doneq.size() == 0 &&
          errq.size() == 0 && cyc > win_hi) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 0, 1);
    chk("ctrl_pe_held", ctrl_pe, h_op);
    chk("mod_held", modulus, h_mod);
    chk("inv_held", modulus_inv, h_inv);
  endtask

  int            a1;
  int            a2;
  bit            ok;
  logic [DW-1:0] rm;
  logic [DW:0]   rmi;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_len = '0;
    cmd_src_base = '0;
    cmd_dst_base = '0;
    cmd_modulus = '0;
    cmd_modulus_inv = '0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(posedge clk); #2;
    rst = 1'b0;

    // Basic job.
    submit(2'b01, 3, 10'h010, 10'h200, 54'h2A_BCDE_F012_3456, 55'h4F_0123_4567_89AB, a1);
    wait_drain();
    // Address wrap on both sides.
    submit(2'b10, 4, 10'h3FE, 10'h3FF, 54'h11_2233_4455_6677, 55'h01_0203_0405_0607, a1);
    wait_drain();
    // Zero-length job.
    submit(2'b00, 0, 10'h123, 10'h045, 54'h05_5555_5555_5555, 55'h6A_AAAA_AAAA_AAAA, a1);
    wait_drain();
    // Reserved op: err pulse, held outputs untouched.
    submit(2'b11, 5, 10'h001, 10'h002, 54'h3F_FFFF_FFFF_FFFF, 55'h7F_FFFF_FFFF_FFFF, a1);
    chk("err_ready_stays", cmd_ready, 1);
    wait_drain();

    // cmd_valid held through a busy job; second accept right after done.
    @(posedge clk); #2;
    drive_cmd(2'b01, 2, 10'h040, 10'h080, 54'h01_1111_1111_1111, 55'h02_2222_2222_2222);
    wait_ready(ok);
    a1 = cyc + 1;
    push_job(a1, 2'b01, 2, 10'h040, 10'h080);
    h_op = 2'b01; h_mod = 54'h01_1111_1111_1111; h_inv = 55'h02_2222_2222_2222;
    @(posedge clk); #2;
    drive_cmd(2'b10, 2, 10'h050, 10'h090, 54'h03_3333_3333_3333, 55'h04_4444_4444_4444);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      chk("mod_held_busy", modulus, 54'h01_1111_1111_1111);
    end
    if (!ok) chk("accept2_timeout", 0, 1);
    a2 = cyc + 1;
    chk("accept2_cyc", a2, a1 + 2 + L + 3);
    push_job(a2, 2'b10, 2, 10'h050, 10'h090);
    h_op = 2'b10; h_mod = 54'h03_3333_3333_3333; h_inv = 55'h04_4444_4444_4444;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mod_switched", modulus, 54'h03_3333_3333_3333);
    wait_drain();

    // Abort mid-job: reset two cycles after the first write.
    submit(2'b01, 8, 10'h100, 10'h300, 54'h12_3456_789A_BCDE, 55'h00_0000_0000_0001, a1);
    for (int i = 0; i < 100; i++) begin
      if (cyc >= a1 + L + 2) break;
      @(posedge clk); #2;
    end
    rst = 1'b1;
    rdq.delete();
    wrq.delete();
    doneq.delete();
    errq.delete();
    win_lo = 1; win_hi = 0;
    h_op = '0; h_mod = '0; h_inv = '0;
    #1 chk_zero("abort_rst");
    @(posedge clk); @(posedge clk); #2;
    chk_zero("abort_rst_hold");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    submit(2'b10, 1, 10'h3FF, 10'h000, 54'h00_0000_0000_00FF, 55'h00_0000_0000_0100, a1);
    wait_drain();

    // Random back-to-back jobs.
    for (int j = 0; j < 8; j++) begin
      rm  = DW'({$urandom, $urandom});
      rmi = (DW + 1)'({$urandom, $urandom});
      submit(2'($urandom_range(0, 3)), $urandom_range(0, 12), AW'($urandom), AW'($urandom),
             rm, rmi, a1);
    end
    wait_drain();

    // Maximum length job.
    submit(2'b01, (1 << LW) - 1, 10'h005, 10'h3F0, 54'h2F_0F0F_0F0F_0F0F, 55'h70_F0F0_F0F0_F0F0, a1);
    wait_drain();

    chk("rdq_left", rdq.size(), 0);
    chk("wrq_left", wrq.size(), 0);
    chk("doneq_left", doneq.size(), 0);
    chk("errq_left", errq.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
